// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: FSM states and forward-select codes.
package hazard_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // M beats W: it holds the younger write to the same register.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       rw_m,
                                          input logic [4:0] wr_m,
                                          input logic       rw_w,
                                          input logic [4:0] wr_w);
      if (src != 5'd0 && rw_m && wr_m == src)      return FWD_M;
      else if (src != 5'd0 && rw_w && wr_w == src) return FWD_W;
      else                                         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle; the datapath is the master side.
interface hazard_ctrl_if;

   logic [4:0] RsD, RtD, RsE, RtE;
   logic [4:0] WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic       MemtoRegE, MemtoRegM;
   logic       BranchD, PCSrcD, PopD, PushE, PopE;
   logic       DmemReqM, DmemReadyM;
   logic       StallF, StallD, StallE, StallM, StallW;
   logic       FlushD, FlushE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD;
   logic       MemErr;

   modport master (
      output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
             BranchD, PCSrcD, PopD, PushE, PopE, DmemReqM, DmemReadyM,
      input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
             ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemErr
   );

   modport slave (
      input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
             BranchD, PCSrcD, PopD, PushE, PopE, DmemReqM, DmemReadyM,
      output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
             ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemErr
   );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Combinational operand-forwarding selects for the E-stage ALU and D-stage compare.
module hazard_fwd_unit
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] i_rs_d,
   input  logic [4:0] i_rt_d,
   input  logic [4:0] i_rs_e,
   input  logic [4:0] i_rt_e,
   input  logic [4:0] i_wreg_m,
   input  logic [4:0] i_wreg_w,
   input  logic       i_regwr_m,
   input  logic       i_regwr_w,
   output logic [1:0] o_fwd_ae,
   output logic [1:0] o_fwd_be,
   output logic       o_fwd_ad,
   output logic       o_fwd_bd
);

   assign o_fwd_ae = fwd_sel(i_rs_e, i_regwr_m, i_wreg_m, i_regwr_w, i_wreg_w);
   assign o_fwd_be = fwd_sel(i_rt_e, i_regwr_m, i_wreg_m, i_regwr_w, i_wreg_w);
   assign o_fwd_ad = (i_rs_d != 5'd0) && i_regwr_m && (i_wreg_m == i_rs_d);
   assign o_fwd_bd = (i_rt_d != 5'd0) && i_regwr_m && (i_wreg_m == i_rt_d);

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: stalls, flushes, forwarding, memory-wait FSM.
// Optional HAZARD_PERF_CNT_EN adds saturating StallCnt/FlushCnt ports.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
)(
   input  logic             CLK,
   input  logic             reset,
`ifdef HAZARD_PERF_CNT_EN
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt,
`endif
   hazard_ctrl_if.slave     hz
);

   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

   hz_state_e     r_st, w_nst;
   logic [TW-1:0] r_wcnt;
   logic          r_memerr, r_rel;
   logic          w_freeze, w_tmo, w_hz;
   logic          w_lwstall, w_brstall, w_spstall;

   hazard_fwd_unit u_fwd (
      .i_rs_d    (hz.RsD),
      .i_rt_d    (hz.RtD),
      .i_rs_e    (hz.RsE),
      .i_rt_e    (hz.RtE),
      .i_wreg_m  (hz.WriteRegM),
      .i_wreg_w  (hz.WriteRegW),
      .i_regwr_m (hz.RegWriteM),
      .i_regwr_w (hz.RegWriteW),
      .o_fwd_ae  (hz.ForwardAE),
      .o_fwd_be  (hz.ForwardBE),
      .o_fwd_ad  (hz.ForwardAD),
      .o_fwd_bd  (hz.ForwardBD)
   );

   assign w_lwstall = hz.MemtoRegE && (hz.RtE == hz.RsD || hz.RtE == hz.RtD);
   assign w_brstall = hz.BranchD &&
                      ((hz.RegWriteE && (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
                       (hz.MemtoRegM && (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));
   assign w_spstall = hz.PopD && (hz.PushE || hz.PopE);
   assign w_hz      = w_lwstall | w_brstall | w_spstall;

   // r_rel masks the request term for one cycle after a timeout so the stuck
   // access can leave M instead of re-entering MEM_WAIT at once.
   always_comb begin
      w_nst    = r_st;
      w_freeze = 1'b0;
      w_tmo    = 1'b0;
      case (r_st)
         RUN: begin
            if (hz.DmemReqM && !hz.DmemReadyM && !r_rel) begin
               w_freeze = 1'b1;
               w_nst    = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (hz.DmemReadyM) begin
               w_nst = RUN;
            end else if (r_wcnt == TMO_LAST) begin
               w_freeze = 1'b1;
               w_tmo    = 1'b1;
               w_nst    = RUN;
            end else begin
               w_freeze = 1'b1;
            end
         end
         default: w_nst = RUN;
      endcase
   end

   assign hz.StallF = w_freeze | w_hz;
   assign hz.StallD = w_freeze | w_hz;
   assign hz.StallE = w_freeze;
   assign hz.StallM = w_freeze;
   assign hz.StallW = w_freeze;
   assign hz.FlushE = w_hz & ~w_freeze;
   assign hz.FlushD = hz.PCSrcD & ~hz.StallD;
   assign hz.MemErr = r_memerr;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_st     <= RUN;
         r_wcnt   <= '0;
         r_memerr <= 1'b0;
         r_rel    <= 1'b0;
      end else begin
         r_st   <= w_nst;
         r_rel  <= w_tmo;
         r_wcnt <= (r_st == MEM_WAIT && w_nst == MEM_WAIT) ? r_wcnt + TW'(1) : '0;
         if (w_tmo) r_memerr <= 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (hz.StallF && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if ((hz.FlushE | hz.FlushD) && r_flush_cnt != '1)
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign StallCnt = r_stall_cnt;
   assign FlushCnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic CLK = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_bad = 0;

   hazard_ctrl_if hif ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .CLK      (CLK),
      .reset    (reset),
`ifdef HAZARD_PERF_CNT_EN
      .StallCnt (stall_cnt),
      .FlushCnt (flush_cnt),
`endif
      .hz       (hif)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      hif.RsD = 0; hif.RtD = 0; hif.RsE = 0; hif.RtE = 0;
      hif.WriteRegE = 0; hif.WriteRegM = 0; hif.WriteRegW = 0;
      hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
      hif.MemtoRegE = 0; hif.MemtoRegM = 0;
      hif.BranchD = 0; hif.PCSrcD = 0; hif.PopD = 0; hif.PushE = 0; hif.PopE = 0;
      hif.DmemReqM = 0; hif.DmemReadyM = 0;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      #3;
      chk("rst_stallF", hif.StallF, 0);
      chk("rst_memerr", hif.MemErr, 0);
      chk("rst_fwdAE",  hif.ForwardAE, FWD_RF);
`ifdef HAZARD_PERF_CNT_EN
      chk("rst_stallcnt", stall_cnt, 0);
`endif
      cyc(); reset = 1'b1; cyc();

      // load-use: lw $2 in E, RsD=2
      hif.MemtoRegE = 1; hif.RegWriteE = 1; hif.RtE = 2; hif.WriteRegE = 2;
      hif.RsD = 2; hif.RtD = 3;
      #2;
      chk("lw_stallF", hif.StallF, 1);
      chk("lw_stallD", hif.StallD, 1);
      chk("lw_flushE", hif.FlushE, 1);
      chk("lw_stallE", hif.StallE, 0);
      cyc(); idle();
      hif.RsE = 2; hif.RegWriteW = 1; hif.WriteRegW = 2;
      #2;
      chk("lw_fwdAE_W", hif.ForwardAE, FWD_W);
      chk("lw_next_stall", hif.StallF, 0);

      cyc(); idle();
      hif.RegWriteM = 1; hif.WriteRegM = 5; hif.RegWriteW = 1; hif.WriteRegW = 5;
      hif.RsE = 5; hif.RtE = 5;
      #2;
      chk("fwdAE_M_wins", hif.ForwardAE, FWD_M);
      chk("fwdBE_M_wins", hif.ForwardBE, FWD_M);
      cyc();
      hif.WriteRegM = 0; hif.WriteRegW = 0; hif.RsE = 0; hif.RtE = 0;
      #2;
      chk("fwdAE_r0", hif.ForwardAE, FWD_RF);
      cyc();
      hif.WriteRegM = 0; hif.RegWriteW = 0; hif.RsE = 5;
      #2;
      chk("fwdAE_none", hif.ForwardAE, FWD_RF);

      cyc(); idle();
      hif.RegWriteM = 1; hif.WriteRegM = 7; hif.RsD = 7; hif.RtD = 8;
      #2;
      chk("fwdAD", hif.ForwardAD, 1);
      chk("fwdBD", hif.ForwardBD, 0);

      // branch depends on E result; taken branch must not flush D while stalled
      cyc(); idle();
      hif.BranchD = 1; hif.PCSrcD = 1; hif.RsD = 4; hif.RegWriteE = 1; hif.WriteRegE = 4;
      #2;
      chk("br_stallD", hif.StallD, 1);
      chk("br_flushE", hif.FlushE, 1);
      chk("br_flushD", hif.FlushD, 0);

      cyc(); idle();
      hif.PopD = 1; hif.PushE = 1;
      #2;
      chk("sp_stallF", hif.StallF, 1);
      chk("sp_flushE", hif.FlushE, 1);
      cyc(); hif.PushE = 0;
      #2;
      chk("sp_clear", hif.StallF, 0);

      cyc(); idle();
      hif.PCSrcD = 1;
      #2;
      chk("br_flushD_taken", hif.FlushD, 1);

      // 3-cycle memory wait from a fresh reset
      cyc(); idle(); reset = 1'b0; cyc(); reset = 1'b1; cyc();
      hif.DmemReqM = 1; hif.MemtoRegE = 1; hif.RtE = 2; hif.RsD = 2;
      #2;
      chk("mw0_stallW", hif.StallW, 1);
      chk("mw0_flushE", hif.FlushE, 0);
      cyc(); hif.MemtoRegE = 0; hif.RtE = 0; hif.RsD = 0;
      #2;
      chk("mw1_stallE", hif.StallE, 1);
      cyc(); hif.PCSrcD = 1;
      #2;
      chk("mw2_stallM", hif.StallM, 1);
      chk("mw2_flushD", hif.FlushD, 0);
      cyc(); hif.PCSrcD = 0; hif.DmemReadyM = 1;
      #2;
      chk("mw3_release", hif.StallF, 0);
      chk("mw3_memerr", hif.MemErr, 0);
      cyc(); idle();
      #2;
      chk("mw_run", hif.StallW, 0);
`ifdef HAZARD_PERF_CNT_EN
      chk("mw_stallcnt", stall_cnt, 3);
      chk("mw_flushcnt0", flush_cnt, 0);
      hif.PCSrcD = 1; cyc(); hif.PCSrcD = 0;
      #2;
      chk("mw_flushcnt1", flush_cnt, 1);
`endif

      // timeout: ready never comes
      cyc(); idle();
      hif.DmemReqM = 1;
      #2;
      chk("to_c0", hif.StallF, 1);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         #2;
         chk("to_wait", hif.StallF, 1);
      end
      chk("to_err_pre", hif.MemErr, 0);
      cyc();
      #2;
      chk("to_memerr", hif.MemErr, 1);
      chk("to_released", hif.StallF, 0);
      hif.DmemReqM = 0;
      cyc();
      #2;
      chk("to_sticky", hif.MemErr, 1);
      chk("to_run", hif.StallE, 0);

      // reset in the middle of a wait
      cyc(); hif.DmemReqM = 1;
      cyc();
      #2;
      chk("rw_waiting", hif.StallE, 1);
      reset = 1'b0; hif.DmemReqM = 0;
      #1;
      chk("rw_drop", hif.StallF, 0);
      chk("rw_memerr", hif.MemErr, 0);
`ifdef HAZARD_PERF_CNT_EN
      chk("rw_stallcnt", stall_cnt, 0);
`endif
      cyc(); reset = 1'b1; cyc();
      #2;
      chk("rw_after", hif.StallW, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
